// File: rtl/viscosity_pid_ctrl.sv
// Viscosity loop controller: N-deep moving average of the sensor, then a
// proportional term around a fixed pump bias, saturated to the pump range.
// Two-stage pipeline: stage 1 updates the average, stage 2 computes the pump
// command. A run of rail-valued samples trips a latched fault.
module viscosity_pid_ctrl #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       AVG_LOG2  = 3,
  parameter int unsigned       KP_W      = 8,
  parameter int unsigned       SHIFT     = 4,
  parameter logic [DATA_W-1:0] PUMP_BIAS = 16'h8000,
  parameter int unsigned       FAULT_CNT = 4
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              enable_i,
  input  logic              sample_valid_i,
  input  logic [DATA_W-1:0] sensor_data_i,
  input  logic [DATA_W-1:0] setpoint_i,
  input  logic [KP_W-1:0]   kp_i,
  output logic [DATA_W-1:0] pump_ctrl_o,
  output logic              pump_valid_o,
  output logic [DATA_W-1:0] filt_data_o,
  output logic [1:0]        state_o,
  output logic              fault_o
);

  localparam int unsigned N      = 1 << AVG_LOG2;
  localparam int unsigned SUM_W  = DATA_W + AVG_LOG2;
  localparam int unsigned FC_W   = $clog2(FAULT_CNT + 1);
  localparam int unsigned PROD_W = DATA_W + KP_W + 2;
  localparam int unsigned OUT_W  = PROD_W + 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StRun   = 2'd2,
    StFault = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [N];
  logic [SUM_W-1:0]    sum_q;
  // In FILL the write pointer doubles as the fill counter (it starts at 0).
  logic [AVG_LOG2-1:0] ptr_q;
  logic [FC_W-1:0]     fcnt_q;
  logic [DATA_W-1:0]   filt_q;
  logic                s1_v_q;
  logic [DATA_W-1:0]   pump_q;
  logic                pump_v_q;
  logic                fault_q;

  logic                     accept, is_rail, trip, s1_v_d, fire;
  logic [SUM_W-1:0]         sum_new;
  logic signed [DATA_W:0]   err;
  logic signed [PROD_W-1:0] prod, shifted;
  logic signed [OUT_W-1:0]  out_full;
  logic [DATA_W-1:0]        sat;

  // Sample acceptance, fault detection, next state and the stage-2 datapath.
  always_comb begin
    accept  = sample_valid_i && enable_i && (state_q == StFill || state_q == StRun);
    is_rail = (&sensor_data_i) || (~|sensor_data_i);
    trip    = accept && is_rail && (fcnt_q == FC_W'(FAULT_CNT - 1));
    sum_new = sum_q + SUM_W'(sensor_data_i) - SUM_W'(mem_q[ptr_q]);
    // Only RUN samples and the sample that completes the fill produce results.
    s1_v_d  = accept && (state_q == StRun || (&ptr_q));

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable_i) state_d = StFill;
      StFill: begin
        if (!enable_i)             state_d = StIdle;
        else if (trip)             state_d = StFault;
        else if (accept && &ptr_q) state_d = StRun;
      end
      StRun: begin
        if (!enable_i)  state_d = StIdle;
        else if (trip)  state_d = StFault;
      end
      StFault: if (!enable_i) state_d = StIdle;
    endcase

    // A stage-1 result is published only if we remain in RUN; leaving RUN
    // (disable or fault) discards anything still in flight.
    fire = s1_v_q && (state_d == StRun);

    err      = $signed({1'b0, filt_q}) - $signed({1'b0, setpoint_i});
    prod     = PROD_W'(err) * PROD_W'($signed({1'b0, kp_i}));
    shifted  = prod >>> SHIFT;
    out_full = OUT_W'(shifted) + OUT_W'($signed({1'b0, PUMP_BIAS}));
    if (out_full[OUT_W-1])                 sat = '0;
    else if (|out_full[OUT_W-2:DATA_W])    sat = '1;
    else                                   sat = out_full[DATA_W-1:0];
  end

  // State, averaging buffer, pipeline and registered outputs.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q  <= StIdle;
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
      sum_q    <= '0;
      ptr_q    <= '0;
      fcnt_q   <= '0;
      filt_q   <= '0;
      s1_v_q   <= 1'b0;
      pump_q   <= '0;
      pump_v_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_v_q   <= s1_v_d;
      pump_v_q <= fire;
      fault_q  <= (state_d == StFault);
      if (state_d != StRun) pump_q <= '0;
      else if (fire)        pump_q <= sat;

      if (state_q == StIdle) begin
        for (int i = 0; i < N; i++) mem_q[i] <= '0;
        sum_q  <= '0;
        ptr_q  <= '0;
        fcnt_q <= '0;
      end else if (accept) begin
        mem_q[ptr_q] <= sensor_data_i;
        sum_q        <= sum_new;
        ptr_q        <= ptr_q + AVG_LOG2'(1);
        filt_q       <= DATA_W'(sum_new >> AVG_LOG2);
        fcnt_q       <= is_rail ? fcnt_q + FC_W'(1) : '0;
      end
    end
  end

  assign pump_ctrl_o  = pump_q;
  assign pump_valid_o = pump_v_q;
  assign filt_data_o  = filt_q;
  assign state_o      = state_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_viscosity_pid_ctrl.sv
// Bench for viscosity_pid_ctrl: table of directed cycles, hand-written corner
// sequences and a randomized run, all checked against a queue-based model.
module tb_viscosity_pid_ctrl;

  localparam int FAULT_CNT = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sensor_data = '0;
  logic [15:0] setpoint = 16'h4000;
  logic [7:0]  kp = 8'd16;
  logic [15:0] pump_ctrl;
  logic        pump_valid;
  logic [15:0] filt_data;
  logic [1:0]  state;
  logic        fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  viscosity_pid_ctrl dut (
    .clk_i         (clk),
    .resetn_i      (resetn),
    .enable_i      (enable),
    .sample_valid_i(sample_valid),
    .sensor_data_i (sensor_data),
    .setpoint_i    (setpoint),
    .kp_i          (kp),
    .pump_ctrl_o   (pump_ctrl),
    .pump_valid_o  (pump_valid),
    .filt_data_o   (filt_data),
    .state_o       (state),
    .fault_o       (fault)
  );

  // Reference model: sample history as a queue, results scheduled by edge index.
  typedef struct {
    int due;
    int f;
  } pend_t;

  int    m_st, m_rail, m_fill, m_filt, m_pump, edge_n;
  bit    m_pv;
  int    hist[$];
  pend_t pq[$];

  function automatic int pump_fn(input int f, input int s, input int k);
    longint e = longint'(f) - longint'(s);
    longint p = e * longint'(k);
    longint q = p / 16;
    longint o;
    if (p < 0 && (p % 16) != 0) q = q - 1;  // floor, i.e. arithmetic shift
    o = 32768 + q;
    if (o < 0) return 0;
    if (o > 65535) return 65535;
    return int'(o);
  endfunction

  task automatic model_reset();
    m_st = 0; m_rail = 0; m_fill = 0; m_filt = 0; m_pump = 0; m_pv = 0;
    hist.delete();
    pq.delete();
  endtask

  task automatic model_edge(input bit en, input bit sv, input int d);
    bit    acc = sv && en && (m_st == 1 || m_st == 2);
    bit    rail = (d == 0) || (d == 'hFFFF);
    int    nst = m_st;
    int    s = 0;
    pend_t p;
    edge_n++;
    if (m_st == 0) begin
      hist.delete(); m_rail = 0; m_fill = 0;
      if (en) nst = 1;
    end else if (!en) begin
      nst = 0;
    end else if (acc) begin
      hist.push_back(d);
      if (hist.size() > 8) void'(hist.pop_front());
      foreach (hist[i]) s += hist[i];
      m_filt = s / 8;
      m_rail = rail ? m_rail + 1 : 0;
      m_fill++;
      if (m_rail >= FAULT_CNT)          nst = 3;
      else if (m_st == 1 && m_fill == 8) nst = 2;
      if (m_st == 2 || m_fill == 8) pq.push_back('{edge_n + 1, m_filt});
    end
    m_st = nst;
    m_pv = 0;
    while (pq.size() > 0 && pq[0].due <= edge_n) begin
      p = pq.pop_front();
      if (p.due == edge_n && m_st == 2) begin
        m_pv = 1;
        m_pump = pump_fn(p.f, int'(setpoint), int'(kp));
      end
    end
    if (m_st != 2) m_pump = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit en, input bit sv, input logic [15:0] d);
    @(negedge clk);
    enable = en; sample_valid = sv; sensor_data = d;
    @(posedge clk);
    model_edge(en, sv, int'(d));
    #1;
    chk("model state", 32'(state), 32'(m_st));
    chk("model pump_valid", 32'(pump_valid), 32'(m_pv));
    chk("model pump_ctrl", 32'(pump_ctrl), 32'(m_pump));
    chk("model filt_data", 32'(filt_data), 32'(m_filt));
    chk("model fault", 32'(fault), 32'(m_st == 3));
  endtask

  typedef struct {
    bit          en;
    bit          sv;
    logic [15:0] d;
    logic [1:0]  st;
    bit          pv;
    logic [15:0] pump;
    logic [15:0] filt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit en, input bit sv, input logic [15:0] d, input logic [1:0] st,
                     input bit pv, input logic [15:0] pump, input logic [15:0] filt);
    tbl.push_back('{en, sv, d, st, pv, pump, filt});
  endtask

  initial begin
    int r;
    logic [15:0] rd;

    // Fill from IDLE at setpoint, then swing high to saturation.
    add(1, 0, 16'h0000, 2'd1, 0, 16'h0000, 16'h0000);
    for (int i = 1; i <= 8; i++)
      add(1, 1, 16'h4000, (i == 8) ? 2'd2 : 2'd1, 0, 16'h0000, 16'(i * 'h800));
    add(1, 0, 16'h0000, 2'd2, 1, 16'h8000, 16'h4000);
    add(1, 0, 16'h0000, 2'd2, 0, 16'h8000, 16'h4000);
    for (int j = 1; j <= 8; j++)
      add(1, 1, 16'hC000, 2'd2, j > 1, (j > 1) ? 16'('h8000 + (j - 1) * 'h1000) : 16'h8000,
          16'('h4000 + j * 'h1000));
    add(1, 0, 16'h0000, 2'd2, 1, 16'hFFFF, 16'hC000);
    add(1, 0, 16'h0000, 2'd2, 0, 16'hFFFF, 16'hC000);

    model_reset();
    edge_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset state", 32'(state), 0);
    chk("reset pump_ctrl", 32'(pump_ctrl), 0);
    chk("reset pump_valid", 32'(pump_valid), 0);
    chk("reset filt_data", 32'(filt_data), 0);
    chk("reset fault", 32'(fault), 0);
    @(negedge clk);
    resetn = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].sv, tbl[i].d);
      chk($sformatf("tbl%0d state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("tbl%0d pump_valid", i), 32'(pump_valid), 32'(tbl[i].pv));
      chk($sformatf("tbl%0d pump_ctrl", i), 32'(pump_ctrl), 32'(tbl[i].pump));
      chk($sformatf("tbl%0d filt_data", i), 32'(filt_data), 32'(tbl[i].filt));
    end

    // Below-setpoint response, then saturation low with a large gain.
    for (int i = 0; i < 8; i++) step(1, 1, 16'h1000);
    step(1, 0, 16'h0000);
    chk("low pump_ctrl", 32'(pump_ctrl), 32'h5000);
    chk("low filt_data", 32'(filt_data), 32'h1000);
    kp = 8'd255;
    step(1, 1, 16'h1000);
    step(1, 0, 16'h0000);
    chk("satlow pump_valid", 32'(pump_valid), 1);
    chk("satlow pump_ctrl", 32'(pump_ctrl), 32'h0000);
    kp = 8'd16;

    // Rail run interrupted by a good sample does not trip; four in a row do.
    for (int i = 0; i < 3; i++) step(1, 1, 16'hFFFF);
    step(1, 1, 16'h4000);
    for (int i = 0; i < 3; i++) step(1, 1, 16'h0000);
    chk("rail3 state", 32'(state), 2);
    chk("rail3 fault", 32'(fault), 0);
    step(1, 1, 16'h0000);
    chk("trip state", 32'(state), 3);
    chk("trip fault", 32'(fault), 1);
    chk("trip pump_ctrl", 32'(pump_ctrl), 0);
    step(1, 1, 16'h4000);
    chk("fault hold pump_valid", 32'(pump_valid), 0);
    step(0, 0, 16'h0000);
    chk("fault exit state", 32'(state), 0);
    chk("fault exit fault", 32'(fault), 0);

    // Disable in the same cycle as a sample: nothing in flight escapes.
    step(1, 0, 16'h0000);
    for (int i = 0; i < 8; i++) step(1, 1, 16'h2000);
    step(1, 1, 16'h3000);
    step(0, 1, 16'h3000);
    chk("drop state", 32'(state), 0);
    chk("drop pump_valid", 32'(pump_valid), 0);
    step(0, 0, 16'h0000);
    chk("drop late pump_valid", 32'(pump_valid), 0);

    // Asynchronous reset while running with a non-zero pump command.
    step(1, 0, 16'h0000);
    for (int i = 0; i < 8; i++) step(1, 1, 16'h5000);
    step(1, 0, 16'h0000);
    chk("prereset pump_ctrl", 32'(pump_ctrl), 32'h9000);
    #2;
    resetn = 1'b0;
    #1;
    chk("async state", 32'(state), 0);
    chk("async pump_ctrl", 32'(pump_ctrl), 0);
    chk("async pump_valid", 32'(pump_valid), 0);
    chk("async filt_data", 32'(filt_data), 0);
    model_reset();
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    step(1, 0, 16'h0000);
    chk("restart pump_valid", 32'(pump_valid), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(15) == 0) setpoint = 16'($urandom);
      if ($urandom_range(15) == 0) kp = 8'($urandom);
      r = int'($urandom_range(5));
      rd = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'($urandom);
      step($urandom_range(19) != 0, $urandom_range(3) != 0, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
